stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_ram.sv | 29 ++
 rtl/stack_unit.sv | 155 +++++++++++++++
 tb/tb_stack_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared op encoding and FSM state types for the stack unit.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port spill RAM for stack entries below NOS: synchronous write, one-cycle read.
module stack_ram #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ENTRIES = 14,
    localparam int unsigned AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_unit.sv
// Hardware stack: TOS/NOS registers over a spill RAM, POP refills NOS in one extra cycle.
// Sticky overflow/underflow flags are built only when STACK_UNIT_ERR_EN is defined.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 op,
    input  logic                       op_valid,
    input  logic [WIDTH-1:0]           din,
    output logic                       ready,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err,
    input  logic                       err_clr
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned RAM_N = DEPTH - 2;
    localparam int unsigned AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ram_we_c, ram_re_c;
    logic [AW-1:0]    ram_addr_c;
    logic [WIDTH-1:0] ram_rdata;
    logic             ovf_set_c, unf_set_c;

    stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (RAM_N)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ram_addr_c),
        .wdata_i (nos_q),
        .rdata_o (ram_rdata)
    );

    // Next-state: ops are taken only in IDLE; REFILL just loads NOS from the RAM.
    always_comb begin
        state_d    = state_q;
        tos_d      = tos_q;
        nos_d      = nos_q;
        count_d    = count_q;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = '0;
        ovf_set_c  = 1'b0;
        unf_set_c  = 1'b0;
        if (state_q == ST_REFILL) begin
            nos_d   = ram_rdata;
            state_d = ST_IDLE;
        end else if (op_valid) begin
            case (op)
                OP_PUSH, OP_DUP: begin
                    if (count_q == CW'(DEPTH)) begin
                        ovf_set_c = 1'b1;
                    end else if ((op == OP_DUP) && (count_q == '0)) begin
                        unf_set_c = 1'b1;
                    end else begin
                        if (count_q >= CW'(2)) begin
                            ram_we_c   = 1'b1;
                            ram_addr_c = AW'(count_q - CW'(2));
                        end
                        nos_d   = tos_q;
                        tos_d   = (op == OP_DUP) ? tos_q : din;
                        count_d = count_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (count_q == '0) begin
                        unf_set_c = 1'b1;
                    end else begin
                        tos_d   = (count_q == CW'(1)) ? '0 : nos_q;
                        count_d = count_q - CW'(1);
                        if (count_q >= CW'(3)) begin
                            ram_re_c   = 1'b1;
                            ram_addr_c = AW'(count_q - CW'(3));
                            state_d    = ST_REFILL;
                        end else begin
                            nos_d = '0;
                        end
                    end
                end
                OP_SWAP: begin
                    if (count_q < CW'(2)) begin
                        unf_set_c = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tos_q   <= '0;
            nos_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            count_q <= count_d;
        end
    end

`ifdef STACK_UNIT_ERR_EN
    logic ovf_q, unf_q;

    // Sticky flags; a new error in the same cycle wins over err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set_c)    ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (unf_set_c)    unf_q <= 1'b1;
            else if (err_clr) unf_q <= 1'b0;
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`else
    logic unused_err;
    assign unused_err = ^{err_clr, ovf_set_c, unf_set_c};
    assign ovf_err    = 1'b0;
    assign unf_err    = 1'b0;
`endif

    assign ready = (state_q == ST_IDLE);
    assign tos   = tos_q;
    assign nos   = nos_q;
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (WIDTH=8, DEPTH=4): directed table then model-driven random ops.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef STACK_UNIT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       op = 3'd0;
    logic             op_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             err_clr = 1'b0;
    logic             ready, full, empty, ovf_err, unf_err;
    logic [WIDTH-1:0] tos, nos;
    logic [2:0]       count;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .op_valid (op_valid),
        .din      (din),
        .ready    (ready),
        .tos      (tos),
        .nos      (nos),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tos;
        logic [7:0] nos;
        bit         nchk;
        int         cnt;
        bit         rdy;
        bit         ovf;
        bit         unf;
    } exp_t;

    typedef struct {
        bit         rst;
        bit         vld;
        logic [2:0] op;
        logic [7:0] din;
        bit         clr;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference: whole stack held top-first in m[], independent of TOS/NOS/RAM split.
    logic [7:0] m[DEPTH];
    int         mcnt = 0;
    bit         mref = 0, movf = 0, munf = 0;

    function automatic vec_t mk(bit r, bit vl, logic [2:0] o, logic [7:0] d, bit c,
                                logic [7:0] et, logic [7:0] en, bit nc, int ec,
                                bit er, bit eo, bit eu);
        vec_t v;
        v.rst = r; v.vld = vl; v.op = o; v.din = d; v.clr = c;
        v.e.tos = et; v.e.nos = en; v.e.nchk = nc; v.e.cnt = ec; v.e.rdy = er;
        v.e.ovf = eo & ERR_EN; v.e.unf = eu & ERR_EN;
        return v;
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h", name, step_id, got, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step %0d got 0 want 1", step_id);
            return;
        end
        e = sb.pop_front();
        cmp("tos", int'(tos), int'(e.tos));
        if (e.nchk) cmp("nos", int'(nos), int'(e.nos));
        cmp("count", int'(count), e.cnt);
        cmp("ready", int'(ready), int'(e.rdy));
        cmp("full", int'(full), int'(e.cnt == DEPTH));
        cmp("empty", int'(empty), int'(e.cnt == 0));
        cmp("ovf_err", int'(ovf_err), int'(e.ovf));
        cmp("unf_err", int'(unf_err), int'(e.unf));
    endtask

    task automatic apply(input bit r, input bit vl, input logic [2:0] o,
                         input logic [7:0] d, input bit c, input exp_t e);
        @(negedge clk);
        rst = r; op_valid = vl; op = o; din = d; err_clr = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
        step_id++;
    endtask

    task automatic mpush(input logic [7:0] v);
        for (int i = DEPTH - 1; i > 0; i--) m[i] = m[i-1];
        m[0] = v;
        mcnt++;
    endtask

    task automatic model(input bit r, input bit vl, input logic [2:0] o,
                         input logic [7:0] d, input bit c, output exp_t e);
        bit oset = 0, uset = 0;
        e.nchk = 1;
        if (r) begin
            mcnt = 0; mref = 0; movf = 0; munf = 0;
        end else begin
            if (mref) begin
                mref = 0;
            end else if (vl) begin
                case (o)
                    3'd1: if (mcnt < DEPTH) mpush(d); else oset = 1;
                    3'd2: if (mcnt == 0) uset = 1;
                          else begin
                              if (mcnt >= 3) begin mref = 1; e.nchk = 0; end
                              for (int i = 0; i < DEPTH - 1; i++) m[i] = m[i+1];
                              mcnt--;
                          end
                    3'd3: if (mcnt == 0) uset = 1;
                          else if (mcnt == DEPTH) oset = 1;
                          else mpush(m[0]);
                    3'd4: if (mcnt < 2) uset = 1;
                          else begin logic [7:0] t; t = m[0]; m[0] = m[1]; m[1] = t; end
                    default: ;
                endcase
            end
            if (ERR_EN) begin
                if (oset) movf = 1; else if (c) movf = 0;
                if (uset) munf = 1; else if (c) munf = 0;
            end
        end
        e.tos = (mcnt >= 1) ? m[0] : 8'h00;
        e.nos = (mcnt >= 2) ? m[1] : 8'h00;
        e.cnt = mcnt;
        e.rdy = !mref;
        e.ovf = movf;
        e.unf = munf;
    endtask

    initial begin
        // rst vld op din clr | tos nos nchk cnt rdy ovf unf
        tbl.push_back(mk(1,0,0,8'h00,0, 8'h00,8'h00,1,0,1,0,0));
        tbl.push_back(mk(0,1,1,8'h11,0, 8'h11,8'h00,1,1,1,0,0));
        tbl.push_back(mk(0,1,1,8'h22,0, 8'h22,8'h11,1,2,1,0,0));
        tbl.push_back(mk(0,1,1,8'h33,0, 8'h33,8'h22,1,3,1,0,0));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h22,8'h00,0,2,0,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0, 8'h22,8'h11,1,2,1,0,0));
        tbl.push_back(mk(0,1,1,8'h33,0, 8'h33,8'h22,1,3,1,0,0));
        tbl.push_back(mk(0,1,1,8'h44,0, 8'h44,8'h33,1,4,1,0,0));
        tbl.push_back(mk(0,1,1,8'h55,0, 8'h44,8'h33,1,4,1,1,0));
        tbl.push_back(mk(0,0,0,8'h00,1, 8'h44,8'h33,1,4,1,0,0));
        tbl.push_back(mk(0,1,3,8'h00,0, 8'h44,8'h33,1,4,1,1,0));
        tbl.push_back(mk(0,0,1,8'h66,1, 8'h44,8'h33,1,4,1,0,0));
        tbl.push_back(mk(0,1,7,8'h77,0, 8'h44,8'h33,1,4,1,0,0));
        tbl.push_back(mk(1,1,1,8'h88,0, 8'h00,8'h00,1,0,1,0,0));
        tbl.push_back(mk(0,1,1,8'hA1,0, 8'hA1,8'h00,1,1,1,0,0));
        tbl.push_back(mk(0,1,1,8'hB2,0, 8'hB2,8'hA1,1,2,1,0,0));
        tbl.push_back(mk(0,1,4,8'h00,0, 8'hA1,8'hB2,1,2,1,0,0));
        tbl.push_back(mk(0,1,3,8'h00,0, 8'hA1,8'hA1,1,3,1,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0, 8'h00,8'h00,1,0,1,0,0));
        tbl.push_back(mk(0,1,1,8'h5A,0, 8'h5A,8'h00,1,1,1,0,0));
        tbl.push_back(mk(0,1,4,8'h00,0, 8'h5A,8'h00,1,1,1,0,1));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h00,8'h00,1,0,1,0,1));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h00,8'h00,1,0,1,0,1));
        tbl.push_back(mk(0,1,3,8'h00,1, 8'h00,8'h00,1,0,1,0,1));
        tbl.push_back(mk(0,0,0,8'h00,1, 8'h00,8'h00,1,0,1,0,0));
        tbl.push_back(mk(0,1,1,8'h01,0, 8'h01,8'h00,1,1,1,0,0));
        tbl.push_back(mk(0,1,1,8'h02,0, 8'h02,8'h01,1,2,1,0,0));
        tbl.push_back(mk(0,1,1,8'h03,0, 8'h03,8'h02,1,3,1,0,0));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h02,8'h00,0,2,0,0,0));
        tbl.push_back(mk(1,1,1,8'hEE,0, 8'h00,8'h00,1,0,1,0,0));
        tbl.push_back(mk(0,1,1,8'h07,0, 8'h07,8'h00,1,1,1,0,0));
        tbl.push_back(mk(0,1,1,8'h08,0, 8'h08,8'h07,1,2,1,0,0));
        tbl.push_back(mk(0,1,1,8'h09,0, 8'h09,8'h08,1,3,1,0,0));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h08,8'h00,0,2,0,0,0));
        tbl.push_back(mk(0,1,1,8'hAA,0, 8'h08,8'h07,1,2,1,0,0));
        tbl.push_back(mk(0,1,1,8'hAA,0, 8'hAA,8'h08,1,3,1,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0, 8'hAA,8'h08,1,3,1,0,0));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h08,8'h00,0,2,0,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0, 8'h08,8'h07,1,2,1,0,0));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h07,8'h00,1,1,1,0,0));
        tbl.push_back(mk(0,1,2,8'h00,0, 8'h00,8'h00,1,0,1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].vld, tbl[i].op, tbl[i].din, tbl[i].clr, tbl[i].e);
        end

        // Random ops against the reference, starting from a reset.
        for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
        for (int i = 0; i < 600; i++) begin
            bit         r, vl, c;
            logic [2:0] o;
            logic [7:0] d;
            exp_t       e;
            r  = (i == 0) || ($urandom_range(0, 39) == 0);
            vl = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 9) == 0);
            o  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            model(r, vl, o, d, c, e);
            apply(r, vl, o, d, c, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
